// File: rtl/operand_stage.sv
// ID/EX operand capture stage: forwards EX/WB results, stalls on load-use hazards,
// and holds resolved operands in a registered valid/ready slot. Optional: OPERAND_PERF_CNT_EN.
module operand_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ABITS = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [ABITS-1:0] a1_i,
  input  logic [ABITS-1:0] a2_i,
  input  logic             use1_i,
  input  logic             use2_i,
  input  logic [XLEN-1:0]  rd1_i,
  input  logic [XLEN-1:0]  rd2_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic             sel_pc_i,
  input  logic             sel_imm_i,
  input  logic [ABITS-1:0] awi_i,
  input  logic             ewi_i,
  input  logic [ABITS-1:0] x_aw_i,
  input  logic             x_ew_i,
  input  logic             x_dv_i,
  input  logic [XLEN-1:0]  x_data_i,
  input  logic [ABITS-1:0] w_aw_i,
  input  logic             w_ew_i,
  input  logic [XLEN-1:0]  w_data_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  op_a_o,
  output logic [XLEN-1:0]  op_b_o,
  output logic [XLEN-1:0]  store_data_o,
  output logic [ABITS-1:0] out_aw_o,
  output logic             out_ew_o
`ifdef OPERAND_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      bubble_cnt_o
`endif
);

  typedef enum logic {RUN, STALL} state_e;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  op_a_q, op_a_d;
  logic [XLEN-1:0]  op_b_q, op_b_d;
  logic [XLEN-1:0]  store_q, store_d;
  logic [ABITS-1:0] out_aw_q, out_aw_d;
  logic             out_ew_q, out_ew_d;

  logic [XLEN-1:0]  rs1v_c, rs2v_c;
  logic             hazard_c, free_c, accept_c;

  // X is the younger producer, so it wins over the writeback port.
  function automatic logic [XLEN-1:0] resolve(
    input logic [ABITS-1:0] addr,
    input logic [XLEN-1:0]  rd,
    input logic [ABITS-1:0] x_aw,
    input logic             x_ew,
    input logic [XLEN-1:0]  x_data,
    input logic [ABITS-1:0] w_aw,
    input logic             w_ew,
    input logic [XLEN-1:0]  w_data
  );
    if (addr == '0)                  return '0;
    else if (x_ew && x_aw == addr)   return x_data;
    else if (w_ew && w_aw == addr)   return w_data;
    else                             return rd;
  endfunction

  always_comb begin
    rs1v_c = resolve(a1_i, rd1_i, x_aw_i, x_ew_i, x_data_i, w_aw_i, w_ew_i, w_data_i);
    rs2v_c = resolve(a2_i, rd2_i, x_aw_i, x_ew_i, x_data_i, w_aw_i, w_ew_i, w_data_i);
  end

  // Only an EX producer whose data is not yet valid (load in flight) blocks issue.
  always_comb begin
    hazard_c = in_valid_i &&
               ((use1_i && a1_i != '0 && x_ew_i && x_aw_i == a1_i && !x_dv_i) ||
                (use2_i && a2_i != '0 && x_ew_i && x_aw_i == a2_i && !x_dv_i));
    free_c   = !out_valid_q || out_ready_i;
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    store_d     = store_q;
    out_aw_d    = out_aw_q;
    out_ew_d    = out_ew_q;
    in_ready_o  = flush_i || (free_c && !hazard_c);
    accept_c    = in_valid_i && in_ready_o && !flush_i;

    if (flush_i) begin
      state_d     = RUN;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        RUN:     if (hazard_c && free_c) state_d = STALL;
        STALL:   if (!hazard_c)          state_d = RUN;
        default:                         state_d = RUN;
      endcase
      if (free_c) begin
        out_valid_d = accept_c;
        if (accept_c) begin
          op_a_d   = sel_pc_i  ? pc_i  : rs1v_c;
          op_b_d   = sel_imm_i ? imm_i : rs2v_c;
          store_d  = rs2v_c;
          out_aw_d = awi_i;
          out_ew_d = ewi_i && (awi_i != '0);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      store_q     <= '0;
      out_aw_q    <= '0;
      out_ew_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      store_q     <= store_d;
      out_aw_q    <= out_aw_d;
      out_ew_q    <= out_ew_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign op_a_o       = op_a_q;
  assign op_b_o       = op_b_q;
  assign store_data_o = store_q;
  assign out_aw_o     = out_aw_q;
  assign out_ew_o     = out_ew_q;

`ifdef OPERAND_PERF_CNT_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  // Counters survive FLUSH; only reset clears them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (hazard_c)                       stall_cnt_q  <= stall_cnt_q + 32'(1);
      if (hazard_c && free_c && !flush_i) bubble_cnt_q <= bubble_cnt_q + 32'(1);
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: forwarding vectors plus stall,
// backpressure, flush and reset sequences.
module tb_operand_stage;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  a1, a2, awi, x_aw, w_aw, out_aw;
  logic        use1, use2, sel_pc, sel_imm, ewi, x_ew, x_dv, w_ew, flush;
  logic [31:0] rd1, rd2, pc, imm, x_data, w_data;
  logic        out_valid, out_ready, out_ew;
  logic [31:0] op_a, op_b, store_data;
`ifdef OPERAND_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  operand_stage dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a1_i(a1), .a2_i(a2), .use1_i(use1), .use2_i(use2),
    .rd1_i(rd1), .rd2_i(rd2), .pc_i(pc), .imm_i(imm),
    .sel_pc_i(sel_pc), .sel_imm_i(sel_imm),
    .awi_i(awi), .ewi_i(ewi),
    .x_aw_i(x_aw), .x_ew_i(x_ew), .x_dv_i(x_dv), .x_data_i(x_data),
    .w_aw_i(w_aw), .w_ew_i(w_ew), .w_data_i(w_data),
    .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .op_a_o(op_a), .op_b_o(op_b), .store_data_o(store_data),
    .out_aw_o(out_aw), .out_ew_o(out_ew)
`ifdef OPERAND_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a1, a2;
    logic        use1, use2;
    logic [31:0] rd1, rd2, pc, imm;
    logic        sel_pc, sel_imm;
    logic [4:0]  awi;
    logic        ewi;
    logic [4:0]  x_aw;
    logic        x_ew, x_dv;
    logic [31:0] x_data;
    logic [4:0]  w_aw;
    logic        w_ew;
    logic [31:0] w_data;
    logic [31:0] e_op_a, e_op_b, e_store;
    logic [4:0]  e_aw;
    logic        e_ew;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    a1 = v.a1; a2 = v.a2; use1 = v.use1; use2 = v.use2;
    rd1 = v.rd1; rd2 = v.rd2; pc = v.pc; imm = v.imm;
    sel_pc = v.sel_pc; sel_imm = v.sel_imm; awi = v.awi; ewi = v.ewi;
    x_aw = v.x_aw; x_ew = v.x_ew; x_dv = v.x_dv; x_data = v.x_data;
    w_aw = v.w_aw; w_ew = v.w_ew; w_data = v.w_data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;

    // X over W over regfile; rs2 from regfile
    v = '0; v.use1 = 1; v.use2 = 1;
    v.a1 = 5; v.rd1 = 32'h11; v.w_aw = 5; v.w_ew = 1; v.w_data = 32'h22;
    v.x_aw = 5; v.x_ew = 1; v.x_dv = 1; v.x_data = 32'h33;
    v.a2 = 3; v.rd2 = 32'h44; v.awi = 9; v.ewi = 1;
    v.e_op_a = 32'h33; v.e_op_b = 32'h44; v.e_store = 32'h44; v.e_aw = 9; v.e_ew = 1;
    vecs.push_back(v);
    v.x_ew = 0; v.e_op_a = 32'h22;
    vecs.push_back(v);
    v.w_ew = 0; v.e_op_a = 32'h11; v.ewi = 0; v.e_ew = 0;
    vecs.push_back(v);
    // x0 never forwards; AWI=0 suppresses write enable
    v = '0; v.use1 = 1; v.use2 = 1;
    v.x_aw = 0; v.x_ew = 1; v.x_dv = 1; v.x_data = 32'hFFFF_FFFF;
    v.rd1 = 32'h5; v.rd2 = 32'h6; v.awi = 0; v.ewi = 1;
    vecs.push_back(v);
    // PC/IMM selects; STORE_DATA still gets forwarded rs2 from W
    v = '0; v.use1 = 1; v.use2 = 1;
    v.sel_pc = 1; v.pc = 32'h1000; v.sel_imm = 1; v.imm = 32'hFFFF_FFF0;
    v.a2 = 6; v.rd2 = 32'h66; v.w_aw = 6; v.w_ew = 1; v.w_data = 32'h77;
    v.awi = 31; v.ewi = 1;
    v.e_op_a = 32'h1000; v.e_op_b = 32'hFFFF_FFF0; v.e_store = 32'h77; v.e_aw = 31; v.e_ew = 1;
    vecs.push_back(v);
    // Pending load matches rs1 but USE1=0: no hazard, value still forwarded
    v = '0; v.a1 = 7; v.x_aw = 7; v.x_ew = 1; v.x_dv = 0; v.x_data = 32'h99;
    v.awi = 4; v.ewi = 1;
    v.e_op_a = 32'h99; v.e_aw = 4; v.e_ew = 1;
    vecs.push_back(v);

    // Reset state
    rst_n = 0; in_valid = 0; out_ready = 1; flush = 0;
    v = '0; drive(v);
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_op_a", op_a, 32'd0);
    check("rst_op_b", op_b, 32'd0);
    check("rst_store", store_data, 32'd0);
    check("rst_aw_ew", {26'd0, out_aw, out_ew}, 32'd0);
    rst_n = 1;
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i]);
      in_valid = 1;
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      tick();
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d_op_a", i), op_a, vecs[i].e_op_a);
      check($sformatf("v%0d_op_b", i), op_b, vecs[i].e_op_b);
      check($sformatf("v%0d_store", i), store_data, vecs[i].e_store);
      check($sformatf("v%0d_out_aw", i), 32'(out_aw), 32'(vecs[i].e_aw));
      check($sformatf("v%0d_out_ew", i), 32'(out_ew), 32'(vecs[i].e_ew));
    end

    // Load-use on rs2, W also matches but hazard must still hold
    v = '0; v.a2 = 7; v.use2 = 1; v.x_aw = 7; v.x_ew = 1; v.x_dv = 0;
    v.w_aw = 7; v.w_ew = 1; v.w_data = 32'h55; v.awi = 8; v.ewi = 1;
    drive(v); in_valid = 1;
    #1;
    check("lu_in_ready0", 32'(in_ready), 32'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("lu_bubble%0d", c), 32'(out_valid), 32'd0);
      check($sformatf("lu_in_ready%0d", c + 1), 32'(in_ready), 32'd0);
    end
    x_dv = 1; x_data = 32'hAB;
    #1;
    check("lu_release_ready", 32'(in_ready), 32'd1);
    tick();
    check("lu_out_valid", 32'(out_valid), 32'd1);
    check("lu_store", store_data, 32'hAB);
    check("lu_op_b", op_b, 32'hAB);
`ifdef OPERAND_PERF_CNT_EN
    check("lu_stall_cnt", stall_cnt, 32'd2);
    check("lu_bubble_cnt", bubble_cnt, 32'd2);
`endif

    // Backpressure holds slot and blocks input
    v = '0; v.sel_pc = 1; v.pc = 32'h100; v.sel_imm = 1; v.imm = 32'h200;
    drive(v); in_valid = 1;
    tick();
    check("bp_loaded", op_a, 32'h100);
    out_ready = 0; pc = 32'h300; imm = 32'h400;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp_in_ready%0d", c), 32'(in_ready), 32'd0);
      tick();
      check($sformatf("bp_valid%0d", c), 32'(out_valid), 32'd1);
      check($sformatf("bp_op_a%0d", c), op_a, 32'h100);
      check($sformatf("bp_op_b%0d", c), op_b, 32'h200);
    end
    out_ready = 1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp_new_op_a", op_a, 32'h300);
    check("bp_new_op_b", op_b, 32'h400);

    // Flush with full, stalled slot: incoming discarded
    out_ready = 0; pc = 32'h500; flush = 1;
    #1;
    check("fl_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("fl_out_valid", 32'(out_valid), 32'd0);
    flush = 0; in_valid = 0; out_ready = 1;
    tick();
    check("fl_no_replay", 32'(out_valid), 32'd0);

    // Async reset mid-stream
    in_valid = 1; pc = 32'h600;
    tick();
    check("mr_loaded", op_a, 32'h600);
    #2 rst_n = 0;
    #1;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_op_a", op_a, 32'd0);
`ifdef OPERAND_PERF_CNT_EN
    check("mr_stall_cnt", stall_cnt, 32'd0);
`endif
    #2 rst_n = 1; pc = 32'h700;
    tick();
    check("mr_first_valid", 32'(out_valid), 32'd1);
    check("mr_first_op_a", op_a, 32'h700);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
